// File: rtl/grey_pkg.sv
// Shared definitions for the grey-scale serial link: state encoding, register
// map, STATUS bit positions and the grey-code step function.
package grey_pkg;

  typedef enum logic [1:0] {
    Sidle   = 2'd0,
    Srecv   = 2'd1,
    Sresync = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_TIMEOUT = 4'd0;
  localparam logic [3:0] ADDR_NBITS   = 4'd4;
  localparam logic [3:0] ADDR_DATA    = 4'd8;
  localparam logic [3:0] ADDR_STATUS  = 4'd12;

  localparam int unsigned ST_VALID    = 0;
  localparam int unsigned ST_STEP_ERR = 1;
  localparam int unsigned ST_OVERRUN  = 2;
  localparam int unsigned ST_TIMEOUT  = 3;

  // Forward order is 0->1->3->2->0; dir=0 walks it backwards.
  function automatic logic [1:0] next_grey(input logic dir, input logic [1:0] cp);
    logic [1:0] nx;
    case (cp)
      2'd0:    nx = dir ? 2'd1 : 2'd2;
      2'd1:    nx = dir ? 2'd3 : 2'd0;
      2'd3:    nx = dir ? 2'd2 : 2'd1;
      default: nx = dir ? 2'd0 : 2'd3;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/grey_scale_rx_if.sv
// Register bus of the grey-scale receiver (addr/rw/datain/dataout).
interface grey_scale_rx_if;
  logic        rw;
  logic [3:0]  addr;
  logic [31:0] datain;
  logic [31:0] dataout;

  modport master (output rw, output addr, output datain, input dataout);
  modport slave  (input rw, input addr, input datain, output dataout);
endinterface

// File: rtl/grey_step_decode.sv
// Classifies the sampled grey code against the reference: forward step,
// backward step, or an illegal double toggle.
module grey_step_decode
  import grey_pkg::*;
(
  input  logic [1:0] i_ref,
  input  logic [1:0] i_ss,
  output logic       o_step_c,
  output logic       o_bit_c,
  output logic       o_err_c
);

  logic w_fwd;
  logic w_bwd;

  assign w_fwd    = (i_ss == next_grey(1'b1, i_ref));
  assign w_bwd    = (i_ss == next_grey(1'b0, i_ref));
  assign o_step_c = w_fwd | w_bwd;
  assign o_bit_c  = w_fwd;
  assign o_err_c  = (i_ss != i_ref) && !(w_fwd | w_bwd);

endmodule

// File: rtl/grey_scale_rx.sv
// Grey-scale serial receiver: decodes grey steps into LSB-first words with
// register bus access. Optional GREY_RX_GLITCH_FILTER_EN adds a 2-sample filter.
module grey_scale_rx
  import grey_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 32
) (
  input  logic              clk,
  input  logic              reset,
  grey_scale_rx_if.slave    bus,
  input  logic [1:0]        ss,
  output logic              rx_valid,
  output logic              rx_err
);

  localparam int unsigned NW = $clog2(DW);

  state_t          r_state;
  logic [1:0]      r_ss_q;
  logic [1:0]      r_ref;
  logic [NW-1:0]   r_bcnt;
  logic [NW-1:0]   r_nbits;
  logic [TW-1:0]   r_idle;
  logic [TW-1:0]   r_timeout;
  logic [DW-1:0]   r_shreg;
  logic [DW-1:0]   r_rxdata;
  logic            r_valid;
  logic            r_step_f;
  logic            r_ovr_f;
  logic            r_to_f;

  logic [1:0]      w_ss_acc;
  logic            w_step;
  logic            w_bit;
  logic            w_err;
  logic            w_rd_data;
  logic            w_wr_status;
  logic            w_done;
  logic            w_to_hit;
  logic [TW:0]     w_idle_inc;
  logic [NW:0]     w_sh;
  logic [DW-1:0]   w_shreg_nx;
  logic [DW-1:0]   w_word;
  logic [3:0]      w_status;

`ifdef GREY_RX_GLITCH_FILTER_EN
  logic [1:0]      r_ss_p;
  // A sample only counts once two consecutive clocks agree on it.
  assign w_ss_acc = (r_ss_q == r_ss_p) ? r_ss_q : r_ref;
`else
  assign w_ss_acc = r_ss_q;
`endif

  grey_step_decode u_dec (
    .i_ref    (r_ref),
    .i_ss     (w_ss_acc),
    .o_step_c (w_step),
    .o_bit_c  (w_bit),
    .o_err_c  (w_err)
  );

  assign w_rd_data   = !bus.rw && (bus.addr == ADDR_DATA);
  assign w_wr_status = bus.rw && (bus.addr == ADDR_STATUS);
  assign w_done      = w_step && (r_state != Sresync) && (r_bcnt == r_nbits);
  assign w_idle_inc  = {1'b0, r_idle} + (TW+1)'(1);
  assign w_to_hit    = (r_timeout != '0) && (w_idle_inc >= {1'b0, r_timeout});

  // Insert the new bit and keep only bits [NBITS:0] of the finished word.
  always_comb begin
    w_shreg_nx         = r_shreg;
    w_shreg_nx[r_bcnt] = w_bit;
    w_sh               = {1'b0, r_nbits} + (NW+1)'(1);
    w_word             = w_shreg_nx & ~({DW{1'b1}} << w_sh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= Sidle;
      r_ss_q    <= '0;
`ifdef GREY_RX_GLITCH_FILTER_EN
      r_ss_p    <= '0;
`endif
      r_ref     <= '0;
      r_bcnt    <= '0;
      r_nbits   <= '0;
      r_idle    <= '0;
      r_timeout <= '0;
      r_shreg   <= '0;
      r_rxdata  <= '0;
      r_valid   <= 1'b0;
      r_step_f  <= 1'b0;
      r_ovr_f   <= 1'b0;
      r_to_f    <= 1'b0;
    end else begin
      r_ss_q <= ss;
`ifdef GREY_RX_GLITCH_FILTER_EN
      r_ss_p <= r_ss_q;
`endif
      // Clears come first so a same-cycle flag set further down wins.
      if (w_wr_status) begin
        if (bus.datain[ST_STEP_ERR]) r_step_f <= 1'b0;
        if (bus.datain[ST_OVERRUN])  r_ovr_f  <= 1'b0;
        if (bus.datain[ST_TIMEOUT])  r_to_f   <= 1'b0;
      end
      if (bus.rw && (bus.addr == ADDR_TIMEOUT)) r_timeout <= bus.datain[TW-1:0];
      if (bus.rw && (bus.addr == ADDR_NBITS))   r_nbits   <= bus.datain[NW-1:0];
      if (w_rd_data) r_valid <= 1'b0;

      if (w_err) begin
        r_step_f <= 1'b1;
        r_ref    <= w_ss_acc;
        r_bcnt   <= '0;
        r_shreg  <= '0;
        r_state  <= Sresync;
      end else begin
        case (r_state)
          Sresync: r_state <= Sidle;
          Sidle, Srecv: begin
            if (w_step) begin
              r_ref  <= w_ss_acc;
              r_idle <= '0;
              if (w_done) begin
                r_rxdata <= w_word;
                r_valid  <= 1'b1;
                if (r_valid && !w_rd_data) r_ovr_f <= 1'b1;
                r_bcnt   <= '0;
                r_shreg  <= '0;
                r_state  <= Sidle;
              end else begin
                r_shreg  <= w_shreg_nx;
                r_bcnt   <= r_bcnt + NW'(1);
                r_state  <= Srecv;
              end
            end else if (r_state == Srecv) begin
              if (r_idle != '1) r_idle <= r_idle + TW'(1);
              if (w_to_hit) begin
                r_to_f  <= 1'b1;
                r_bcnt  <= '0;
                r_shreg <= '0;
                r_state <= Sidle;
              end
            end
          end
          default: r_state <= Sidle;
        endcase
      end
    end
  end

  always_comb begin
    w_status              = '0;
    w_status[ST_VALID]    = r_valid;
    w_status[ST_STEP_ERR] = r_step_f;
    w_status[ST_OVERRUN]  = r_ovr_f;
    w_status[ST_TIMEOUT]  = r_to_f;
  end

  always_comb begin
    bus.dataout = '0;
    if (!bus.rw) begin
      case (bus.addr)
        ADDR_TIMEOUT: bus.dataout = 32'(r_timeout);
        ADDR_NBITS:   bus.dataout = 32'(r_nbits);
        ADDR_DATA:    bus.dataout = 32'(r_rxdata);
        ADDR_STATUS:  bus.dataout = 32'(w_status);
        default:      bus.dataout = '0;
      endcase
    end
  end

  assign rx_valid = r_valid;
  assign rx_err   = r_step_f | r_ovr_f | r_to_f;

endmodule

// File: tb/tb_grey_scale_rx.sv
// Bench for grey_scale_rx: directed scenarios then random line/bus traffic,
// all compared every cycle against a position-on-the-grey-ring model.
module tb_grey_scale_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ss;
  logic        rx_valid;
  logic        rx_err;

  grey_scale_rx_if bus();

  grey_scale_rx dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ss       (ss),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  always #5 clk = ~clk;

`ifdef GREY_RX_GLITCH_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cur_ss;
  logic [31:0] last_dout;

  // Grey ring 0,1,3,2: ring[k] is the code at position k, ring_pos[g] its position.
  int ring [4]     = '{0, 1, 3, 2};
  int ring_pos [4] = '{0, 1, 3, 2};

  // Reference model state
  int     m_ref, m_ssq, m_ssp, m_mode, m_cnt, m_word, m_nbits, m_data;
  longint m_idle, m_timeout;
  bit     m_valid, m_to, m_ovr, m_serr;

  function automatic int fwd(input int g);
    return ring[(ring_pos[g] + 1) % 4];
  endfunction

  function automatic int bwd(input int g);
    return ring[(ring_pos[g] + 3) % 4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_dout(input bit rw, input int addr);
    if (rw) return 32'h0;
    case (addr)
      0:  return 32'(m_timeout);
      4:  return 32'(m_nbits);
      8:  return 32'(m_data);
      12: return 32'(m_to * 8 + m_ovr * 4 + m_serr * 2 + int'(m_valid));
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the receiver (mode: 0 idle, 1 receiving, 2 resync).
  task automatic model_edge(input bit rst, input bit rw, input int addr, input longint din, input int ss_in);
    int v, d;
    bit rd, old_valid;
    if (rst) begin
      m_ref = 0; m_ssq = 0; m_ssp = 0; m_mode = 0; m_cnt = 0; m_word = 0;
      m_nbits = 0; m_data = 0; m_idle = 0; m_timeout = 0;
      m_valid = 0; m_to = 0; m_ovr = 0; m_serr = 0;
      return;
    end
    rd = !rw && addr == 8;
    old_valid = m_valid;
`ifdef GREY_RX_GLITCH_FILTER_EN
    v = (m_ssq == m_ssp) ? m_ssq : m_ref;
`else
    v = m_ssq;
`endif
    d = (ring_pos[v] - ring_pos[m_ref] + 4) % 4;
    if (rw && addr == 12) begin
      if (din[1]) m_serr = 0;
      if (din[2]) m_ovr = 0;
      if (din[3]) m_to = 0;
    end
    if (rd) m_valid = 0;
    if (d == 2) begin
      m_serr = 1; m_ref = v; m_cnt = 0; m_word = 0; m_mode = 2;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (d != 0) begin
      m_ref = v;
      m_idle = 0;
      if (d == 1) m_word = m_word | (1 << m_cnt);
      else        m_word = m_word & ~(1 << m_cnt);
      if (m_cnt == m_nbits) begin
        m_data = m_word & ((1 << (m_nbits + 1)) - 1);
        if (old_valid && !rd) m_ovr = 1;
        m_valid = 1; m_cnt = 0; m_word = 0; m_mode = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 16;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (m_timeout != 0 && m_idle + 1 >= m_timeout) begin
        m_to = 1; m_cnt = 0; m_word = 0; m_mode = 0;
      end
      if (m_idle < 64'hFFFF_FFFF) m_idle = m_idle + 1;
    end
    if (rw && addr == 0) m_timeout = din & 64'hFFFF_FFFF;
    if (rw && addr == 4) m_nbits = int'(din & 15);
    m_ssp = m_ssq;
    m_ssq = ss_in;
  endtask

  // One bus cycle: drive, check dataout, clock, check status outputs.
  task automatic cyc(input bit rw_i, input int addr_i, input longint din_i, input int ss_i);
    bus.rw = rw_i;
    bus.addr = 4'(addr_i);
    bus.datain = 32'(din_i);
    ss = 2'(ss_i);
    #1;
    last_dout = bus.dataout;
    chk("dataout", bus.dataout, exp_dout(rw_i, addr_i));
    @(posedge clk);
    model_edge(reset, rw_i, addr_i, din_i, ss_i);
    #1;
    chk("rx_valid", 32'(rx_valid), 32'(m_valid));
    chk("rx_err", 32'(rx_err), 32'(m_to | m_ovr | m_serr));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2, 0, cur_ss);
  endtask

  task automatic wr(input int addr, input longint data);
    cyc(1'b1, addr, data, cur_ss);
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
    cyc(1'b0, addr, 0, cur_ss);
    chk(tag, last_dout, exp);
  endtask

  task automatic send_word(input int w, input int n);
    for (int i = 0; i < n; i++) begin
      cur_ss = ((w >> i) & 1) ? fwd(cur_ss) : bwd(cur_ss);
      idle(2);
    end
  endtask

  initial begin
    int r, b;
    int t1 [4] = '{1, 3, 1, 3};
    reset = 1'b1; ss = 2'd0; cur_ss = 0;
    bus.rw = 1'b0; bus.addr = 4'd2; bus.datain = 32'h0;
    repeat (2) @(posedge clk);
    model_edge(1'b1, 1'b0, 2, 0, 0);
    #1;
    // Reset state
    rd_chk("rst_timeout", 0, 32'h0);
    rd_chk("rst_nbits", 4, 32'h0);
    rd_chk("rst_rxdata", 8, 32'h0);
    rd_chk("rst_status", 12, 32'h0);
    reset = 1'b0;

    // 4-bit frame 1,1,0,1 -> 0xB with end-to-end latency
    wr(4, 3);
    for (int i = 0; i < 3; i++) begin
      cur_ss = t1[i];
      idle(4);
    end
    cur_ss = t1[3];
    idle(LAT - 1);
    chk("t1_valid_early", 32'(rx_valid), 32'h0);
    idle(1);
    chk("t1_valid_ontime", 32'(rx_valid), 32'h1);
    idle(2);
    rd_chk("t1_status", 12, 32'h1);
    rd_chk("t1_rxdata", 8, 32'hB);
    rd_chk("t1_status_rd", 12, 32'h0);

    // Step error 0->3, resync to 3, then 3->2 is a one-bit frame (NBITS=0)
    reset = 1'b1; cur_ss = 0; idle(1); reset = 1'b0;
    cur_ss = 3; idle(3);
    chk("t2_rx_err", 32'(rx_err), 32'h1);
    rd_chk("t2_status", 12, 32'h2);
    cur_ss = 2; idle(3);
    rd_chk("t2_rxdata", 8, 32'h1);
    wr(12, 2);
    rd_chk("t2_status_clr", 12, 32'h0);

    // Timeout mid-frame, then a full frame proves the bit counter restarted
    wr(0, 10); wr(4, 7);
    send_word(2'b01, 2);
    idle(14);
    rd_chk("t3_status", 12, 32'h8);
    chk("t3_valid", 32'(rx_valid), 32'h0);
    wr(12, 8); wr(0, 0);
    send_word(8'hC6, 8);
    rd_chk("t3_rxdata", 8, 32'hC6);

    // Overrun, then completion coinciding with an RXDATA read
    wr(4, 3);
    send_word(4'hA, 4);
    send_word(4'h5, 4);
    rd_chk("t4_status_ovr", 12, 32'h5);
    rd_chk("t4_rxdata", 8, 32'h5);
    chk("t4_valid_clr", 32'(rx_valid), 32'h0);
    wr(12, 4);
    send_word(4'h3, 4);
    send_word(4'h6, 3);
    cur_ss = bwd(cur_ss);
    idle(LAT - 1);
    rd_chk("t4_rd_old", 8, 32'h3);
    chk("t4_valid_kept", 32'(rx_valid), 32'h1);
    rd_chk("t4_status_noovr", 12, 32'h1);
    rd_chk("t4_rxdata_new", 8, 32'h6);

    // Reset mid-frame, then a clean frame from ref=0
    send_word(2'b11, 2);
    reset = 1'b1; cur_ss = 0; idle(1); reset = 1'b0;
    rd_chk("t5_nbits", 4, 32'h0);
    rd_chk("t5_rxdata", 8, 32'h0);
    rd_chk("t5_status", 12, 32'h0);
    wr(4, 3);
    send_word(4'h9, 4);
    rd_chk("t5_rxdata_new", 8, 32'h9);

`ifdef GREY_RX_GLITCH_FILTER_EN
    cyc(1'b0, 2, 0, fwd(cur_ss));
    idle(4);
    rd_chk("glitch_status", 12, 32'h0);
`endif

    // Random line activity and bus traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      cur_ss = fwd(cur_ss);
      else if (r < 20) cur_ss = bwd(cur_ss);
      else if (r < 22) cur_ss = cur_ss ^ 3;
      reset = ($urandom_range(0, 999) == 0);
      b = int'($urandom_range(0, 99));
      if (b < 5)       wr(4, $urandom_range(0, 5));
      else if (b < 6)  wr(4, $urandom_range(0, 15));
      else if (b < 9)  wr(0, $urandom_range(0, 12));
      else if (b < 13) wr(12, $urandom_range(0, 15));
      else if (b < 14) wr(8, $urandom);
      else if (b < 40) cyc(1'b0, int'($urandom_range(0, 15)), 0, cur_ss);
      else             idle(1);
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/grey_scale_rx.md
Name: grey_scale_rx

Overview:
- Receiver for the 2-bit grey-scale serial line driven by the team's grey-scale transmitter.
- Samples ss and decodes each grey step into one bit: a forward step is 1, a backward step is 0. Bits are assembled LSB first into a 16-bit word.
- Exposes the transmitter's register bus style (addr/rw/datain/dataout) for configuration, data readback and status.
- Sits directly downstream of the transmitter, on the far side of the link.

Parameters:
- DW, 16, maximum received word width; nbits field is clog2(DW) wide.
- TW, 32, idle-timeout counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- rw  in  1  1 = write datain to addr; 0 = read addr onto dataout.
- addr  in  4  register address: 0, 4, 8 or 12.
- datain  in  32  write data.
- dataout  out  32  combinational read data; 0 for unmapped addresses and whenever rw=1.
- ss  in  2  grey-scale line from the transmitter.
- rx_valid  out  1  a received word is waiting in RXDATA.
- rx_err  out  1  OR of the sticky error flags.

Behaviour:
- Register map:
  - 0 TIMEOUT [31:0], R/W; 0 disables the timeout.
  - 4 NBITS [3:0], R/W; coded n-1.
  - 8 RXDATA [15:0], RO; read clears rx_valid.
  - 12 STATUS {timeout_f, overrun_f, step_err_f, rx_valid}, bits [3:0]; flags are write-1-to-clear, rx_valid is RO.
- Reset (sync): TIMEOUT=0, NBITS=0, RXDATA=0, all flags=0, ss_q=0, ref=0, bcnt=0, idle=0, state=Sidle, dataout=0.
- Sampling and decode:
  - ss is registered into ss_q every cycle. ref holds the last accepted grey code.
  - When ss_q != ref: next_grey(1,ref)==ss_q gives bit 1; next_grey(0,ref)==ss_q gives bit 0; any other change (both bits toggled) is a step error.
  - Forward sequence: 0->1->3->2->0.
- FSM:
  - Sidle: first valid step -> Srecv. The bit is accepted, ref<=ss_q, bcnt<=1.
  - Srecv, valid step: shreg[bcnt]<=bit, ref<=ss_q, idle<=0.
    - If bcnt==NBITS: RXDATA<=assembled word zero-extended above bit NBITS, rx_valid<=1, bcnt<=0, go to Sidle.
    - Otherwise bcnt<=bcnt+1.
  - Srecv, no change: idle<=idle+1. When TIMEOUT!=0 and idle+1>=TIMEOUT: timeout_f<=1, bcnt<=0, shreg<=0, go to Sidle.
  - Step error in any state: step_err_f<=1, ref<=ss_q (resync), partial word discarded, bcnt<=0, go to Sresync.
  - Sresync: lasts exactly one cycle, then Sidle.
  - NBITS=0 gives one-bit frames; the first step completes the frame directly from Sidle.
- Latency: an ss change on edge N is sampled at N+1. The final bit's rx_valid and RXDATA update at N+2.
- Overrun: a frame completes while rx_valid=1 and RXDATA is not read in the same cycle -> RXDATA is overwritten and overrun_f<=1.
- Simultaneous completion and RXDATA read: the old value is returned on dataout, the new word is loaded, rx_valid stays 1 and overrun_f is not set.
- Writes:
  - Writing NBITS or TIMEOUT mid-frame takes effect from the next cycle's compare; the frame is not aborted.
  - Writes to 8 are ignored.
  - W1C and a flag set in the same cycle: the set wins.
- idle saturates at all-ones and never wraps.

Optional Feature:
- Macro: GREY_RX_GLITCH_FILTER_EN.
- Defined:
  - Adds a second sample register. ss_q is accepted only when equal to the previous sample, i.e. stable for 2 consecutive clocks.
  - Single-cycle glitches are ignored and decode latency grows by 1 (rx_valid at N+3).
- Undefined: behaviour exactly as above.

Decomposition:
- Package grey_pkg holds:
  - next_grey(dir, cp) function, shared with the transmitter.
  - State enum {Sidle, Srecv, Sresync}.
  - Register address constants ADDR_DIV/TIMEOUT=0, ADDR_NBITS=4, ADDR_DATA=8, ADDR_STATUS=12.
  - STATUS bit index constants.
- One sub-module, grey_step_decode: takes ref and ss_q, outputs {step, bit, err}.

Test Plan:
- NBITS=3; ss from 0: 1,3,1,3, each held 4 clocks -> RXDATA=0x000B, rx_valid=1 two clocks after the last change, STATUS=0x1.
- ss jumps 0->3 -> step_err_f=1, rx_err=1, ref=3. Then 3->2 decodes as bit 1. Write 0x2 to 12 clears step_err_f.
- TIMEOUT=10, NBITS=7, send 2 steps then hold -> timeout_f=1 after 10 idle clocks, bcnt=0, rx_valid stays 0.
- Two 4-bit frames (0xA then 0x5) without reading -> RXDATA=0x5, overrun_f=1. A read of 8 returns 0x5 and clears rx_valid.
- reset asserted after 2 bits of a 4-bit frame -> every register and flag returns to its reset value on the next edge; a fresh frame then decodes correctly from ref=0.
- With GREY_RX_GLITCH_FILTER_EN: a 1-clock 0->1->0 pulse on ss produces no bit and no error.
